bwn_layer_seq: RTL

Parametrised sequencer for one binary-weight (BWN) convolution layer. It replaces the fixed 13-state controller with a generic PRE/ROW/LAST/DONE machine whose row count and lengths are parameters. It adds multi-stage continuous runs, stall, abort and a registered result capture. It drives the shift enable and the weight/threshold ROM addresses of an external BWN core, then latches the core's BL-bit output.

---
 rtl/bwn_layer_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bwn_layer_seq.sv
// Parametrised sequencer for one binary-weight convolution layer: PRE/ROW/LAST/DONE
// with continuous multi-stage runs, stall, abort and a registered result capture.
module bwn_layer_seq #(
    parameter int BL        = 154,
    parameter int AW        = 6,
    parameter int PRE_CNT   = 60,
    parameter int ROW_LEN   = 17,
    parameter int SHIFT_LEN = 14,
    parameter int NROW      = 10,
    parameter int LAST_LEN  = 14
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic          iABORT,
    input  logic          iSTALL,
    input  logic          iMODE,
    input  logic [AW-1:0] iSTAGE,
    input  logic [AW-1:0] iNUM_STAGE,
    input  logic [BL-1:0] iCORE_DATA,
    output logic          oSHIFT_EN,
    output logic [AW-1:0] oW_ADDR,
    output logic [AW-1:0] oTH_ADDR,
    output logic          oBUSY,
    output logic          oEND,
    output logic          oVALID,
    output logic [BL-1:0] oDATA
);

    localparam int MAX_PR = (PRE_CNT > ROW_LEN) ? PRE_CNT : ROW_LEN;
    localparam int MAXC   = (MAX_PR > LAST_LEN) ? MAX_PR : LAST_LEN;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int RW     = (NROW > 0) ? $clog2(NROW + 1) : 1;

    localparam logic [CW-1:0] PRE_END   = CW'(PRE_CNT - 1);
    localparam logic [CW-1:0] ROW_END   = CW'(ROW_LEN - 1);
    localparam logic [CW-1:0] LAST_END  = CW'(LAST_LEN - 1);
    localparam logic [RW-1:0] ROW_FINAL = RW'((NROW > 0) ? NROW - 1 : 0);
    localparam logic [CW:0]   SHIFT_END = (CW + 1)'(SHIFT_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ROW,
        S_LAST,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [BL-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          end_q, end_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = 1'b0;

        if (iABORT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            row_d   = '0;
        end else if (state_q == S_IDLE) begin
            if (iSTART) begin
                state_d     = S_PRE;
                cnt_d       = '0;
                row_d       = '0;
                addr_d      = iSTAGE;
                remaining_d = (iMODE && (iNUM_STAGE != '0)) ? iNUM_STAGE - 1'b1 : '0;
            end
        end else if (!iSTALL) begin
            case (state_q)
                S_PRE: begin
                    if (cnt_q == PRE_END) begin
                        cnt_d   = '0;
                        row_d   = '0;
                        state_d = (NROW > 0) ? S_ROW : S_LAST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ROW: begin
                    if (cnt_q == ROW_END) begin
                        cnt_d = '0;
                        row_d = row_q + 1'b1;
                        if (row_q == ROW_FINAL) begin
                            state_d = S_LAST;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_LAST: begin
                    if (cnt_q == LAST_END) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Capture on the edge that leaves DONE; the core output is final here.
                    data_d  = iCORE_DATA;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    row_d   = '0;
                    if (remaining_q != '0) begin
                        state_d     = S_PRE;
                        addr_d      = addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Status flags are precomputed from the next state so they come straight off flops.
        shift_d = ((state_d == S_ROW) && ({1'b0, cnt_d} < SHIFT_END)) || (state_d == S_LAST);
        busy_d  = (state_d != S_IDLE);
        end_d   = (state_d == S_DONE);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            shift_q     <= 1'b0;
            busy_q      <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            end_q       <= end_d;
        end
    end

    // A stall must silence the core in the same cycle, hence the only combinational gate.
    assign oSHIFT_EN = shift_q & ~iSTALL;
    assign oW_ADDR   = addr_q;
    assign oTH_ADDR  = addr_q;
    assign oBUSY     = busy_q;
    assign oEND      = end_q;
    assign oVALID    = valid_q;
    assign oDATA     = data_q;

endmodule
